// File: rtl/knap_search_if.sv
// Bus bundle for knap_search: item-table load port, search limits, control and results.
// The bench drives the master side; the search engine takes the slave side.
interface knap_search_if #(
    parameter int N_ITEMS = 8,
    parameter int DAT_W   = 8,
    parameter int SUM_W   = 12
);
    localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    logic               ld_en;
    logic [IDX_W-1:0]   ld_idx;
    logic [DAT_W-1:0]   ld_value;
    logic [DAT_W-1:0]   ld_weight;
    logic [DAT_W-1:0]   ld_volume;
    logic [SUM_W-1:0]   max_weight;
    logic [SUM_W-1:0]   max_volume;
    logic [SUM_W-1:0]   min_value;
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic [N_ITEMS-1:0] best_sel;
    logic [SUM_W-1:0]   best_value;
    logic               found;

    modport master (
        output ld_en, ld_idx, ld_value, ld_weight, ld_volume,
        output max_weight, max_volume, min_value, start, abort,
        input  busy, done, best_sel, best_value, found
    );

    modport slave (
        input  ld_en, ld_idx, ld_value, ld_weight, ld_volume,
        input  max_weight, max_volume, min_value, start, abort,
        output busy, done, best_sel, best_value, found
    );
endinterface

// File: rtl/knap_search.sv
// Exhaustive 0/1 knapsack search with two capacity constraints (weight, volume).
// One subset is evaluated per SCAN cycle; the earliest strictly-best feasible subset wins.
module knap_search #(
    parameter int N_ITEMS = 8,
    parameter int DAT_W   = 8,
    parameter int SUM_W   = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    knap_search_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [N_ITEMS-1:0] idx_q, idx_d;
    logic [DAT_W-1:0]   val_q [N_ITEMS];
    logic [DAT_W-1:0]   val_d [N_ITEMS];
    logic [DAT_W-1:0]   wt_q  [N_ITEMS];
    logic [DAT_W-1:0]   wt_d  [N_ITEMS];
    logic [DAT_W-1:0]   vol_q [N_ITEMS];
    logic [DAT_W-1:0]   vol_d [N_ITEMS];
    logic [SUM_W-1:0]   max_w_q, max_w_d;
    logic [SUM_W-1:0]   max_v_q, max_v_d;
    logic [SUM_W-1:0]   min_val_q, min_val_d;
    logic [N_ITEMS-1:0] best_sel_q, best_sel_d;
    logic [SUM_W-1:0]   best_value_q, best_value_d;
    logic               done_q, done_d;
    logic               found_q, found_d;

    logic [SUM_W-1:0]   value_sum;
    logic [SUM_W-1:0]   weight_sum;
    logic [SUM_W-1:0]   volume_sum;
    logic               feasible;
    logic               better;
    logic               last_idx;
    logic [SUM_W-1:0]   final_value;

    // Subset evaluation: SUM_W is wide enough that these sums never wrap.
    always_comb begin
        value_sum  = '0;
        weight_sum = '0;
        volume_sum = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (idx_q[i]) begin
                value_sum  = value_sum  + SUM_W'(val_q[i]);
                weight_sum = weight_sum + SUM_W'(wt_q[i]);
                volume_sum = volume_sum + SUM_W'(vol_q[i]);
            end
        end
        feasible    = (weight_sum <= max_w_q) && (volume_sum <= max_v_q);
        // Strict compare keeps the lower-index subset on ties.
        better      = feasible && (value_sum > best_value_q);
        last_idx    = &idx_q;
        final_value = better ? value_sum : best_value_q;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start && !bus.abort) state_d = SCAN;
            SCAN: if (bus.abort || last_idx)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        idx_d        = idx_q;
        max_w_d      = max_w_q;
        max_v_d      = max_v_q;
        min_val_d    = min_val_q;
        best_sel_d   = best_sel_q;
        best_value_d = best_value_q;
        found_d      = found_q;
        done_d       = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            val_d[i] = val_q[i];
            wt_d[i]  = wt_q[i];
            vol_d[i] = vol_q[i];
        end

        case (state_q)
            IDLE: begin
                for (int i = 0; i < N_ITEMS; i++) begin
                    if (bus.ld_en && (bus.ld_idx == $bits(bus.ld_idx)'(i))) begin
                        val_d[i] = bus.ld_value;
                        wt_d[i]  = bus.ld_weight;
                        vol_d[i] = bus.ld_volume;
                    end
                end
                if (bus.start && !bus.abort) begin
                    max_w_d      = bus.max_weight;
                    max_v_d      = bus.max_volume;
                    min_val_d    = bus.min_value;
                    idx_d        = '0;
                    best_sel_d   = '0;
                    best_value_d = '0;
                    found_d      = 1'b0;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    idx_d        = '0;
                    best_sel_d   = '0;
                    best_value_d = '0;
                    found_d      = 1'b0;
                end else begin
                    idx_d = idx_q + N_ITEMS'(1);
                    if (better) begin
                        best_sel_d   = idx_q;
                        best_value_d = value_sum;
                    end
                    if (last_idx) begin
                        done_d  = 1'b1;
                        found_d = (final_value >= min_val_q);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            max_w_q      <= '0;
            max_v_q      <= '0;
            min_val_q    <= '0;
            best_sel_q   <= '0;
            best_value_q <= '0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) begin
                val_q[i] <= '0;
                wt_q[i]  <= '0;
                vol_q[i] <= '0;
            end
        end else begin
            idx_q        <= idx_d;
            max_w_q      <= max_w_d;
            max_v_q      <= max_v_d;
            min_val_q    <= min_val_d;
            best_sel_q   <= best_sel_d;
            best_value_q <= best_value_d;
            done_q       <= done_d;
            found_q      <= found_d;
            for (int i = 0; i < N_ITEMS; i++) begin
                val_q[i] <= val_d[i];
                wt_q[i]  <= wt_d[i];
                vol_q[i] <= vol_d[i];
            end
        end
    end

    assign bus.busy       = (state_q == SCAN);
    assign bus.done       = done_q;
    assign bus.best_sel   = best_sel_q;
    assign bus.best_value = best_value_q;
    assign bus.found      = found_q;
endmodule

// File: tb/tb_knap_search.sv
// Bench for knap_search: directed cases plus randomized tables checked against
// a brute-force knapsack reference computed directly from the item arrays.
module tb_knap_search;
    localparam int N    = 8;
    localparam int DW   = 8;
    localparam int SW   = 12;
    localparam int NSUB = 1 << N;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    knap_search_if #(.N_ITEMS(N), .DAT_W(DW), .SUM_W(SW)) bus_i ();
    knap_search #(.N_ITEMS(N), .DAT_W(DW), .SUM_W(SW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_i)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int tv [N];
    int tw [N];
    int tvol [N];

    logic [N-1:0]  r_sel;
    logic [SW-1:0] r_val;
    logic          r_fnd;
    int            r_lat;
    bit            r_done;
    int            m_sel, m_val;
    int            pulses;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Brute force over every subset; the first strictly-larger feasible value wins.
    task automatic model(input int mw, input int mv, output int bsel, output int bval);
        bsel = 0;
        bval = 0;
        for (int s = 0; s < NSUB; s++) begin
            int v = 0, w = 0, vo = 0;
            for (int i = 0; i < N; i++) begin
                if (s[i]) begin
                    v += tv[i]; w += tw[i]; vo += tvol[i];
                end
            end
            if (w <= mw && vo <= mv && v > bval) begin
                bsel = s;
                bval = v;
            end
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus_i.ld_en     = 1'b1;
            bus_i.ld_idx    = 3'(i);
            bus_i.ld_value  = 8'(tv[i]);
            bus_i.ld_weight = 8'(tw[i]);
            bus_i.ld_volume = 8'(tvol[i]);
        end
        @(negedge clk);
        bus_i.ld_en = 1'b0;
    endtask

    task automatic set_defaults();
        int v[N]  = '{4, 8, 0, 20, 10, 12, 18, 14};
        int w[N]  = '{28, 8, 27, 18, 27, 28, 6, 1};
        int vo[N] = '{27, 27, 4, 4, 0, 24, 4, 20};
        for (int i = 0; i < N; i++) begin
            tv[i] = v[i]; tw[i] = w[i]; tvol[i] = vo[i];
        end
    endtask

    // lat counts negedges after the start edge; done is expected at lat == NSUB.
    task automatic run_search(input int mw, input int mv, input int mn,
                              input bit late_start, input bit poke_mid);
        @(negedge clk);
        bus_i.max_weight = 12'(mw);
        bus_i.max_volume = 12'(mv);
        bus_i.min_value  = 12'(mn);
        bus_i.start      = 1'b1;
        @(negedge clk);
        bus_i.start = 1'b0;
        check("busy_after_start", 64'(bus_i.busy), 64'(1));
        r_lat  = 0;
        r_done = 1'b0;
        while (r_lat < NSUB + 20) begin
            if (bus_i.done) begin
                r_done = 1'b1;
                break;
            end
            bus_i.start = 1'b0;
            bus_i.ld_en = 1'b0;
            if (late_start && r_lat == NSUB - 1) bus_i.start = 1'b1;
            if (poke_mid && r_lat == 50) begin
                bus_i.start     = 1'b1;
                bus_i.ld_en     = 1'b1;
                bus_i.ld_idx    = 3'd0;
                bus_i.ld_value  = 8'd200;
                bus_i.ld_weight = 8'd0;
                bus_i.ld_volume = 8'd0;
            end
            @(negedge clk);
            r_lat++;
        end
        bus_i.start = 1'b0;
        bus_i.ld_en = 1'b0;
        r_sel = bus_i.best_sel;
        r_val = bus_i.best_value;
        r_fnd = bus_i.found;
        check("done_seen", 64'(r_done), 64'(1));
        check("latency", 64'(r_lat), 64'(NSUB));
        check("busy_at_done", 64'(bus_i.busy), 64'(0));
    endtask

    initial begin
        rst_n            = 1'b0;
        bus_i.ld_en      = 1'b0;
        bus_i.ld_idx     = '0;
        bus_i.ld_value   = '0;
        bus_i.ld_weight  = '0;
        bus_i.ld_volume  = '0;
        bus_i.max_weight = '0;
        bus_i.max_volume = '0;
        bus_i.min_value  = '0;
        bus_i.start      = 1'b0;
        bus_i.abort      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus_i.busy), 64'(0));
        check("rst_done", 64'(bus_i.done), 64'(0));
        check("rst_sel", 64'(bus_i.best_sel), 64'(0));
        check("rst_val", 64'(bus_i.best_value), 64'(0));
        check("rst_found", 64'(bus_i.found), 64'(0));
        rst_n = 1'b1;

        set_defaults();
        load_table();
        run_search(60, 60, 70, 1'b0, 1'b0);
        check("dflt_sel", 64'(r_sel), 64'h0DA);
        check("dflt_val", 64'(r_val), 64'(70));
        check("dflt_found", 64'(r_fnd), 64'(1));
        @(negedge clk);
        check("done_one_cycle", 64'(bus_i.done), 64'(0));
        check("hold_sel", 64'(bus_i.best_sel), 64'h0DA);
        check("hold_found", 64'(bus_i.found), 64'(1));

        run_search(60, 60, 71, 1'b0, 1'b0);
        check("min71_sel", 64'(r_sel), 64'h0DA);
        check("min71_val", 64'(r_val), 64'(70));
        check("min71_found", 64'(r_fnd), 64'(0));

        run_search(0, 0, 0, 1'b0, 1'b0);
        check("zero_sel", 64'(r_sel), 64'(0));
        check("zero_val", 64'(r_val), 64'(0));
        check("zero_found", 64'(r_fnd), 64'(1));

        // Start and item writes during SCAN, plus a start coinciding with done, are ignored.
        run_search(60, 60, 70, 1'b1, 1'b1);
        check("ign_sel", 64'(r_sel), 64'h0DA);
        check("ign_val", 64'(r_val), 64'(70));
        @(negedge clk);
        check("late_start_ignored", 64'(bus_i.busy), 64'(0));
        run_search(60, 60, 70, 1'b0, 1'b0);
        check("table_unchanged", 64'(r_sel), 64'h0DA);

        // Abort at SCAN cycle 100
        @(negedge clk);
        bus_i.max_weight = 12'd60; bus_i.max_volume = 12'd60; bus_i.min_value = 12'd0;
        bus_i.start = 1'b1;
        @(negedge clk);
        bus_i.start = 1'b0;
        repeat (99) @(negedge clk);
        bus_i.abort = 1'b1;
        @(negedge clk);
        bus_i.abort = 1'b0;
        check("abort_busy", 64'(bus_i.busy), 64'(0));
        check("abort_sel", 64'(bus_i.best_sel), 64'(0));
        check("abort_val", 64'(bus_i.best_value), 64'(0));
        check("abort_found", 64'(bus_i.found), 64'(0));
        pulses = 0;
        for (int c = 0; c < NSUB + 20; c++) begin
            @(negedge clk);
            if (bus_i.done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'(0));

        // Reset in the middle of a search
        @(negedge clk);
        bus_i.start = 1'b1;
        @(negedge clk);
        bus_i.start = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 64'(bus_i.busy), 64'(0));
        check("mrst_sel", 64'(bus_i.best_sel), 64'(0));
        check("mrst_val", 64'(bus_i.best_value), 64'(0));
        check("mrst_found", 64'(bus_i.found), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < NSUB + 20; c++) begin
            @(negedge clk);
            if (bus_i.done) pulses++;
        end
        check("mrst_no_done", 64'(pulses), 64'(0));
        run_search(4000, 4000, 1, 1'b0, 1'b0);
        check("tbl_cleared_val", 64'(r_val), 64'(0));
        check("tbl_cleared_found", 64'(r_fnd), 64'(0));

        // Start on the first edge after reset release
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_i.start = 1'b1;
        @(negedge clk);
        bus_i.start = 1'b0;
        check("first_start", 64'(bus_i.busy), 64'(1));
        bus_i.abort = 1'b1;
        @(negedge clk);
        bus_i.abort = 1'b0;
        check("first_start_abort", 64'(bus_i.busy), 64'(0));

        // Tie between items 0 and 1
        for (int i = 0; i < N; i++) begin
            tv[i] = 0; tw[i] = 0; tvol[i] = 0;
        end
        tv[0] = 5; tw[0] = 10; tvol[0] = 10;
        tv[1] = 5; tw[1] = 10; tvol[1] = 10;
        load_table();
        run_search(10, 10, 0, 1'b0, 1'b0);
        check("tie_sel", 64'(r_sel), 64'h01);
        check("tie_val", 64'(r_val), 64'(5));

        for (int t = 0; t < 8; t++) begin
            int mw, mv, mn;
            for (int i = 0; i < N; i++) begin
                tv[i]   = int'($urandom_range(0, 255));
                tw[i]   = int'($urandom_range(0, 255));
                tvol[i] = int'($urandom_range(0, 255));
            end
            mw = int'($urandom_range(0, 1200));
            mv = int'($urandom_range(0, 1200));
            mn = int'($urandom_range(0, 900));
            load_table();
            model(mw, mv, m_sel, m_val);
            run_search(mw, mv, mn, 1'b0, 1'b0);
            check("rand_sel", 64'(r_sel), 64'(m_sel));
            check("rand_val", 64'(r_val), 64'(m_val));
            check("rand_found", 64'(r_fnd), 64'(m_val >= mn));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
